usb_packet_tx: RTL and testbench

Device-side USB low-speed packet transmitter. It is the TX counterpart of the token decoder in usb_controller. It builds handshake packets (ACK/NAK/STALL) and data packets (DATA0/DATA1 with CRC16) and streams their bytes to the PHY over the tx_data/tx_valid/tx_ready interface. It sits between endpoint logic, which issues send requests and supplies payload by address, and the serializer/NRZI PHY.

---
 rtl/usb_packet_tx_if.sv | 30 +++
 rtl/usb_packet_tx.sv | 169 ++++++++++++++++
 tb/tb_usb_packet_tx.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/usb_packet_tx_if.sv
// Endpoint/PHY side signals of the low-speed packet transmitter.
// The slave modport is the transmitter. The master modport is the endpoint logic plus the PHY.
interface usb_packet_tx_if #(
    parameter int MAX_LEN = 8
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic          send_req;
    logic [3:0]    send_pid;
    logic [LW-1:0] send_len;
    logic [AW-1:0] pl_addr;
    logic [7:0]    pl_data;
    logic          busy;
    logic          done;
    logic          req_error;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;

    modport slave (
        input  send_req, send_pid, send_len, pl_data, tx_ready,
        output pl_addr, busy, done, req_error, tx_data, tx_valid
    );

    modport master (
        output send_req, send_pid, send_len, pl_data, tx_ready,
        input  pl_addr, busy, done, req_error, tx_data, tx_valid
    );
endinterface

// File: rtl/usb_packet_tx.sv
// USB low-speed device-side packet transmitter: sends handshake packets and DATA0/DATA1 packets with CRC16.
// Bytes go to the PHY over tx_data/tx_valid/tx_ready. A fixed idle gap follows each EOP.
module usb_packet_tx #(
    parameter int MAX_LEN    = 8,
    parameter int GAP_CYCLES = 32
) (
    input  logic           clk,
    input  logic           reset,
    usb_packet_tx_if.slave bus
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [LW-1:0] MAX_LEN_W = LW'(MAX_LEN);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PID    = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_CRC_LO = 3'd3;
    localparam logic [2:0] S_CRC_HI = 3'd4;
    localparam logic [2:0] S_GAP    = 3'd5;

    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    logic [2:0]    r_state;
    logic [3:0]    r_pid;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_cnt;
    logic [AW-1:0] r_addr;
    logic [15:0]   r_crc;
    logic [GW-1:0] r_gap;
    logic [7:0]    r_tx_data;
    logic          r_tx_valid;
    logic          r_busy;
    logic          r_done;
    logic          r_req_error;

    logic          w_req_is_data;
    logic          w_req_is_hs;
    logic          w_req_legal;
    logic          w_is_data;
    logic          w_more;
    logic [LW-1:0] w_cnt_nxt;
    logic          w_addr_adv;
    logic [15:0]   w_crc_nxt;

    // Reflected CRC16 (0xA001), data bits consumed LSB first
    function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) begin
                c = (c >> 1) ^ 16'hA001;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    always_comb begin
        w_req_is_data = (bus.send_pid == PID_DATA0) || (bus.send_pid == PID_DATA1);
        w_req_is_hs   = (bus.send_pid == PID_ACK) || (bus.send_pid == PID_NAK) ||
                        (bus.send_pid == PID_STALL);
        w_req_legal   = w_req_is_hs || (w_req_is_data && (bus.send_len <= MAX_LEN_W));
        w_is_data     = (r_pid == PID_DATA0) || (r_pid == PID_DATA1);
        w_more        = r_cnt < r_len;
        w_cnt_nxt     = r_cnt + 1'b1;
        w_addr_adv    = w_cnt_nxt < r_len;
        w_crc_nxt     = crc16_upd(r_crc, bus.pl_data);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_pid       <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_crc       <= '1;
            r_gap       <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_req_error <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_req_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The cycle carrying done still counts as busy for request purposes
                    if (bus.send_req && !r_done) begin
                        if (w_req_legal) begin
                            r_pid      <= bus.send_pid;
                            r_len      <= w_req_is_data ? bus.send_len : '0;
                            r_cnt      <= '0;
                            r_addr     <= '0;
                            r_crc      <= '1;
                            r_tx_data  <= {~bus.send_pid, bus.send_pid};
                            r_tx_valid <= 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= S_PID;
                        end else begin
                            r_req_error <= 1'b1;
                        end
                    end
                end
                S_PID, S_DATA: begin
                    if (bus.tx_ready) begin
                        if (r_state == S_PID && !w_is_data) begin
                            r_tx_valid <= 1'b0;
                            r_gap      <= '0;
                            r_state    <= S_GAP;
                        end else if (w_more) begin
                            r_tx_data <= bus.pl_data;
                            r_crc     <= w_crc_nxt;
                            r_cnt     <= w_cnt_nxt;
                            if (w_addr_adv) begin
                                r_addr <= AW'(w_cnt_nxt);
                            end
                            r_state <= S_DATA;
                        end else begin
                            r_tx_data <= ~r_crc[7:0];
                            r_state   <= S_CRC_LO;
                        end
                    end
                end
                S_CRC_LO: begin
                    if (bus.tx_ready) begin
                        r_tx_data <= ~r_crc[15:8];
                        r_state   <= S_CRC_HI;
                    end
                end
                S_CRC_HI: begin
                    if (bus.tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_gap      <= '0;
                        r_state    <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.pl_addr   = r_addr;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.req_error = r_req_error;
    assign bus.tx_data   = r_tx_data;
    assign bus.tx_valid  = r_tx_valid;

endmodule

// File: tb/tb_usb_packet_tx.sv
// Directed bench for usb_packet_tx: a MAX_LEN=9 instance for the packet flows, a MAX_LEN=8 instance for length limits.
module tb_usb_packet_tx;
    logic clk;
    logic rst_n;
    int   n_err;
    int   n_checks;

    logic [7:0] msg [16];

    usb_packet_tx_if #(.MAX_LEN(9)) bus9 ();
    usb_packet_tx_if #(.MAX_LEN(8)) bus8 ();

    usb_packet_tx #(.MAX_LEN(9), .GAP_CYCLES(32)) dut9 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus9.slave)
    );

    usb_packet_tx #(.MAX_LEN(8), .GAP_CYCLES(32)) dut8 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus8.slave)
    );

    assign bus9.pl_data = msg[bus9.pl_addr];
    assign bus8.pl_data = 8'hA5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send9(input logic [3:0] pid, input logic [3:0] len);
        bus9.send_req = 1'b1;
        bus9.send_pid = pid;
        bus9.send_len = len;
        step();
        bus9.send_req = 1'b0;
    endtask

    task automatic ready9();
        bus9.tx_ready = 1'b1;
        step();
        bus9.tx_ready = 1'b0;
    endtask

    task automatic wait_done9(output int n);
        n = 0;
        while (bus9.done !== 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic run_data9(input int spacing, input string tag);
        logic [7:0] held;
        int changes;
        int maxaddr;
        int n;
        send9(4'b0011, 4'd9);
        chk({tag, "_pid"}, bus9.tx_data, 8'hC3);
        chk({tag, "_addr0"}, bus9.pl_addr, 0);
        maxaddr = 0;
        for (int i = 0; i < 9; i++) begin
            held = bus9.tx_data;
            changes = 0;
            for (int k = 0; k < spacing; k++) begin
                step();
                if (bus9.tx_data !== held) changes++;
                if (int'(bus9.pl_addr) > maxaddr) maxaddr = int'(bus9.pl_addr);
            end
            if (spacing > 0) chk({tag, "_stable"}, changes, 0);
            ready9();
            chk({tag, "_byte"}, bus9.tx_data, 32'h31 + i);
            chk({tag, "_addr"}, bus9.pl_addr, (i < 8) ? i + 1 : 8);
            if (int'(bus9.pl_addr) > maxaddr) maxaddr = int'(bus9.pl_addr);
        end
        ready9();
        chk({tag, "_crclo"}, bus9.tx_data, 8'hC8);
        ready9();
        chk({tag, "_crchi"}, bus9.tx_data, 8'hB4);
        chk({tag, "_valid_hi"}, bus9.tx_valid, 1'b1);
        ready9();
        chk({tag, "_valid_fall"}, bus9.tx_valid, 1'b0);
        chk({tag, "_addr_max"}, maxaddr, 8);
        wait_done9(n);
        chk({tag, "_gap"}, n, 32);
    endtask

    initial begin
        int n;
        int vseen;
        n_err = 0;
        n_checks = 0;
        for (int i = 0; i < 16; i++) msg[i] = (i < 9) ? 8'(8'h31 + i) : 8'h00;
        rst_n = 1'b0;
        bus9.send_req = 1'b0; bus9.send_pid = '0; bus9.send_len = '0; bus9.tx_ready = 1'b0;
        bus8.send_req = 1'b0; bus8.send_pid = '0; bus8.send_len = '0; bus8.tx_ready = 1'b0;
        repeat (3) step();

        chk("rst_valid", bus9.tx_valid, 1'b0);
        chk("rst_data", bus9.tx_data, 8'h00);
        chk("rst_busy", bus9.busy, 1'b0);
        chk("rst_done", bus9.done, 1'b0);
        chk("rst_err", bus9.req_error, 1'b0);
        chk("rst_addr", bus9.pl_addr, 0);
        rst_n = 1'b1;
        step();

        // ACK with a spurious tx_ready and an ignored request inside the gap
        send9(4'b0010, 4'd0);
        chk("ack_valid", bus9.tx_valid, 1'b1);
        chk("ack_data", bus9.tx_data, 8'hD2);
        chk("ack_busy", bus9.busy, 1'b1);
        repeat (3) step();
        chk("ack_hold", bus9.tx_data, 8'hD2);
        ready9();
        chk("ack_fall", bus9.tx_valid, 1'b0);
        chk("ack_busy_gap", bus9.busy, 1'b1);
        n = 0;
        vseen = 0;
        while (bus9.done !== 1'b1 && n < 100) begin
            if (n == 5) bus9.tx_ready = 1'b1;
            if (n == 10) begin
                bus9.send_req = 1'b1;
                bus9.send_pid = 4'b0010;
            end
            step();
            bus9.tx_ready = 1'b0;
            bus9.send_req = 1'b0;
            if (bus9.tx_valid !== 1'b0) vseen++;
            n++;
        end
        chk("ack_gap", n, 32);
        chk("ack_gap_quiet", vseen, 0);
        chk("ack_done_busy", bus9.busy, 1'b0);
        send9(4'b0010, 4'd0);
        chk("done_req_ignored", bus9.tx_valid, 1'b0);
        chk("done_pulse", bus9.done, 1'b0);
        step();
        chk("done_req_idle", bus9.busy, 1'b0);

        send9(4'b1010, 4'd0);
        chk("nak_data", bus9.tx_data, 8'h5A);
        ready9();
        wait_done9(n);
        chk("nak_gap", n, 32);
        step();
        send9(4'b1110, 4'd0);
        chk("stall_data", bus9.tx_data, 8'h1E);
        ready9();
        chk("stall_fall", bus9.tx_valid, 1'b0);
        wait_done9(n);
        step();

        // Zero-length DATA1 with a request arriving mid-packet
        send9(4'b1011, 4'd0);
        chk("zlp_pid", bus9.tx_data, 8'h4B);
        ready9();
        chk("zlp_crclo", bus9.tx_data, 8'h00);
        send9(4'b1010, 4'd0);
        chk("zlp_req_busy", bus9.tx_data, 8'h00);
        chk("zlp_req_err", bus9.req_error, 1'b0);
        ready9();
        chk("zlp_crchi", bus9.tx_data, 8'h00);
        chk("zlp_valid", bus9.tx_valid, 1'b1);
        ready9();
        chk("zlp_fall", bus9.tx_valid, 1'b0);
        wait_done9(n);
        chk("zlp_gap", n, 32);
        step();

        run_data9(128, "d0bp");
        step();

        send9(4'b1101, 4'd0);
        chk("setup_err", bus9.req_error, 1'b1);
        chk("setup_valid", bus9.tx_valid, 1'b0);
        chk("setup_busy", bus9.busy, 1'b0);
        step();
        chk("setup_err_pulse", bus9.req_error, 1'b0);

        bus8.send_req = 1'b1; bus8.send_pid = 4'b0011; bus8.send_len = 4'd9;
        step();
        bus8.send_req = 1'b0;
        chk("len9_err", bus8.req_error, 1'b1);
        chk("len9_busy", bus8.busy, 1'b0);
        chk("len9_valid", bus8.tx_valid, 1'b0);
        bus8.send_req = 1'b1; bus8.send_pid = 4'b0011; bus8.send_len = 4'd8;
        step();
        bus8.send_req = 1'b0;
        chk("len8_err", bus8.req_error, 1'b0);
        chk("len8_busy", bus8.busy, 1'b1);
        chk("len8_pid", bus8.tx_data, 8'hC3);

        // Asynchronous reset after the second payload byte
        send9(4'b0011, 4'd3);
        ready9();
        ready9();
        chk("mid_byte2", bus9.tx_data, 8'h32);
        chk("mid_addr", bus9.pl_addr, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus9.tx_valid, 1'b0);
        chk("mid_rst_busy", bus9.busy, 1'b0);
        chk("mid_rst_addr", bus9.pl_addr, 0);
        chk("mid_rst_busy8", bus8.busy, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        run_data9(0, "d0rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
